// File: rtl/tpg_ctrl_mux_shadowed.sv
// Test pattern generator control: shadowed Avalon-MM CSR bank (staging -> active on SOF),
// optional auto-cycling through sources, and a registered pixel source mux.
module tpg_ctrl_mux_shadowed #(
    parameter int          DW            = 32,
    parameter int          DATA_WIDTH    = 24,
    parameter int          SRC_NUM       = 5,
    parameter int          ADDR_W        = 3,
    parameter int          WIDTH         = 800,
    parameter int          HEIGHT        = 600,
    parameter int          OFFSET_FRAMES = 25,
    parameter int          INTERLACED    = 3,
    parameter int          DEF_SRC       = 0,
    parameter logic [23:0] DEF_COLOR     = 24'h0000FF
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [ADDR_W-1:0]             avs_address_i,
    input  logic                          avs_write_i,
    input  logic [DW-1:0]                 avs_writedata_i,
    input  logic                          avs_read_i,
    output logic [DW-1:0]                 avs_readdata_o,
    output logic                          avs_readdatavalid_o,
    input  logic                          sof_i,
    input  logic                          pix_valid_i,
    input  logic [SRC_NUM*DATA_WIDTH-1:0] src_data_i,
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic                          valid_o,
    output logic                          enable_o,
    output logic                          mode_bw_o,
    output logic [31:0]                   width_o,
    output logic [31:0]                   height_o,
    output logic [7:0]                    offset_frames_o,
    output logic [5:0]                    interlaced_o,
    output logic [23:0]                   color_onecolor_o,
    output logic [3:0]                    src_sel_o,
    output logic                          update_pending_o
);

    typedef struct packed {
        logic        en;
        logic        bw;
        logic        ac;
        logic [3:0]  src;
        logic [7:0]  off;
        logic [7:0]  cyc;
        logic [31:0] width;
        logic [31:0] height;
        logic [5:0]  il;
        logic [23:0] col;
    } cfg_t;

    localparam cfg_t CFG_RST = '{
        en: 1'b1, bw: 1'b0, ac: 1'b0, src: 4'(DEF_SRC), off: 8'(OFFSET_FRAMES),
        cyc: 8'd0, width: 32'(WIDTH), height: 32'(HEIGHT), il: 6'(INTERLACED),
        col: DEF_COLOR
    };
    localparam logic [3:0] SRC_LAST = 4'(SRC_NUM - 1);

    cfg_t                  cfg_s_q, cfg_s_d;
    cfg_t                  cfg_a_q, cfg_a_d;
    logic                  pending_q, pending_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic [DW-1:0]         rdata_q, rdata_d;
    logic                  rdv_q, rdv_d;

    logic [31:0] wd;
    logic [31:0] rd_word;
    logic [3:0]  src_idx;
    logic [3:0]  src_next;
    logic        commit_wr;
    logic        apply;
    logic        auto_on;

    assign wd = avs_writedata_i[31:0];

    // Out-of-range selections fall back to the one-colour source.
    assign src_idx  = (cfg_a_q.src > SRC_LAST) ? SRC_LAST : cfg_a_q.src;
    assign src_next = (src_idx == SRC_LAST) ? 4'd0 : src_idx + 4'd1;

    assign commit_wr = avs_write_i && (int'(avs_address_i) == 0) && wd[3];
    // A commit landing on the SOF cycle itself waits for the following SOF.
    assign apply     = sof_i && pending_q && !commit_wr;
    assign auto_on   = cfg_a_q.ac && (cfg_a_q.cyc != 8'd0);

    always_comb begin
        cfg_s_d = cfg_s_q;
        if (avs_write_i) begin
            case (int'(avs_address_i))
                0: begin
                    cfg_s_d.en  = wd[0];
                    cfg_s_d.bw  = wd[1];
                    cfg_s_d.ac  = wd[2];
                    cfg_s_d.src = wd[7:4];
                    cfg_s_d.off = wd[15:8];
                    cfg_s_d.cyc = wd[23:16];
                end
                1: cfg_s_d.width  = wd;
                2: cfg_s_d.height = wd;
                3: begin
                    cfg_s_d.il  = wd[5:0];
                    cfg_s_d.col = wd[31:8];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        pending_d = commit_wr || (pending_q && !apply);
        cfg_a_d   = cfg_a_q;
        cnt_d     = cnt_q;
        if (apply) begin
            cfg_a_d = cfg_s_q;
            cnt_d   = 8'd0;
        end else if (!auto_on) begin
            cnt_d = 8'd0;
        end else if (sof_i) begin
            if (cnt_q == cfg_a_q.cyc - 8'd1) begin
                cnt_d       = 8'd0;
                cfg_a_d.src = src_next;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        valid_d = pix_valid_i && cfg_a_q.en;
        data_d  = valid_d ? src_data_i[int'(src_idx)*DATA_WIDTH +: DATA_WIDTH] : data_q;
    end

    always_comb begin
        case (int'(avs_address_i))
            0:       rd_word = {8'h00, cfg_s_q.cyc, cfg_s_q.off, cfg_s_q.src, 1'b0,
                                cfg_s_q.ac, cfg_s_q.bw, cfg_s_q.en};
            1:       rd_word = cfg_s_q.width;
            2:       rd_word = cfg_s_q.height;
            3:       rd_word = {cfg_s_q.col, 2'b00, cfg_s_q.il};
            4:       rd_word = {8'h00, cnt_q, 8'h00, cfg_a_q.src, 3'b000, pending_q};
            default: rd_word = 32'd0;
        endcase
        rdv_d   = avs_read_i;
        rdata_d = rdata_q;
        if (avs_read_i) begin
            rdata_d       = '0;
            rdata_d[31:0] = rd_word;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cfg_s_q   <= CFG_RST;
            cfg_a_q   <= CFG_RST;
            pending_q <= 1'b0;
            cnt_q     <= 8'd0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            rdata_q   <= '0;
            rdv_q     <= 1'b0;
        end else begin
            cfg_s_q   <= cfg_s_d;
            cfg_a_q   <= cfg_a_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            rdata_q   <= rdata_d;
            rdv_q     <= rdv_d;
        end
    end

    assign avs_readdata_o      = rdata_q;
    assign avs_readdatavalid_o = rdv_q;
    assign data_o              = data_q;
    assign valid_o             = valid_q;
    assign enable_o            = cfg_a_q.en;
    assign mode_bw_o           = cfg_a_q.bw;
    assign width_o             = cfg_a_q.width;
    assign height_o            = cfg_a_q.height;
    assign offset_frames_o     = cfg_a_q.off;
    assign interlaced_o        = cfg_a_q.il;
    assign color_onecolor_o    = cfg_a_q.col;
    assign src_sel_o           = cfg_a_q.src;
    assign update_pending_o    = pending_q;

endmodule

// File: tb/tb_tpg_ctrl_mux_shadowed.sv
// Directed bench for tpg_ctrl_mux_shadowed: reset values, shadowed commit, auto-cycle,
// source clamp, enable gating, CSR read path and asynchronous reset.
module tb_tpg_ctrl_mux_shadowed;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [2:0]    avs_address_i;
    logic          avs_write_i;
    logic [31:0]   avs_writedata_i;
    logic          avs_read_i;
    logic [31:0]   avs_readdata_o;
    logic          avs_readdatavalid_o;
    logic          sof_i;
    logic          pix_valid_i;
    logic [119:0]  src_data_i;
    logic [23:0]   data_o;
    logic          valid_o;
    logic          enable_o;
    logic          mode_bw_o;
    logic [31:0]   width_o;
    logic [31:0]   height_o;
    logic [7:0]    offset_frames_o;
    logic [5:0]    interlaced_o;
    logic [23:0]   color_onecolor_o;
    logic [3:0]    src_sel_o;
    logic          update_pending_o;

    int n_cmp = 0;
    int n_bad = 0;

    tpg_ctrl_mux_shadowed dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .avs_address_i(avs_address_i), .avs_write_i(avs_write_i),
        .avs_writedata_i(avs_writedata_i), .avs_read_i(avs_read_i),
        .avs_readdata_o(avs_readdata_o), .avs_readdatavalid_o(avs_readdatavalid_o),
        .sof_i(sof_i), .pix_valid_i(pix_valid_i), .src_data_i(src_data_i),
        .data_o(data_o), .valid_o(valid_o), .enable_o(enable_o), .mode_bw_o(mode_bw_o),
        .width_o(width_o), .height_o(height_o), .offset_frames_o(offset_frames_o),
        .interlaced_o(interlaced_o), .color_onecolor_o(color_onecolor_o),
        .src_sel_o(src_sel_o), .update_pending_o(update_pending_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
        avs_address_i = a; avs_writedata_i = d; avs_write_i = 1'b1;
        tick();
        avs_write_i = 1'b0;
    endtask

    task automatic csr_read(input logic [2:0] a);
        avs_address_i = a; avs_read_i = 1'b1;
        tick();
        avs_read_i = 1'b0;
    endtask

    task automatic sof_pulse();
        sof_i = 1'b1;
        tick();
        sof_i = 1'b0;
    endtask

    task automatic load_sources();
        for (int k = 0; k < 5; k++) src_data_i[k*24 +: 24] = 24'(32'h111111 * (k + 1));
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", valid_o); end
        n_cmp++; if (data_o !== 24'h0) begin n_bad++; $display("FAIL rst_data: got %h want 000000", data_o); end
        n_cmp++; if (width_o !== 32'd800) begin n_bad++; $display("FAIL rst_width: got %0d want 800", width_o); end
        n_cmp++; if (height_o !== 32'd600) begin n_bad++; $display("FAIL rst_height: got %0d want 600", height_o); end
        n_cmp++; if (color_onecolor_o !== 24'h0000FF) begin n_bad++; $display("FAIL rst_color: got %h want 0000ff", color_onecolor_o); end
        n_cmp++; if (src_sel_o !== 4'd0) begin n_bad++; $display("FAIL rst_src: got %0d want 0", src_sel_o); end
        n_cmp++; if (enable_o !== 1'b1 || mode_bw_o !== 1'b0) begin n_bad++; $display("FAIL rst_en_bw: got %b%b want 10", enable_o, mode_bw_o); end
        n_cmp++; if (offset_frames_o !== 8'd25 || interlaced_o !== 6'd3) begin n_bad++; $display("FAIL rst_off_il: got %0d/%0d want 25/3", offset_frames_o, interlaced_o); end
        n_cmp++; if (update_pending_o !== 1'b0) begin n_bad++; $display("FAIL rst_pending: got %b want 0", update_pending_o); end
        n_cmp++; if (avs_readdatavalid_o !== 1'b0 || avs_readdata_o !== 32'h0) begin n_bad++; $display("FAIL rst_read: got %b/%h want 0/0", avs_readdatavalid_o, avs_readdata_o); end
        rst_i = 1'b1;
        pix_valid_i = 1'b1;
        tick();
        n_cmp++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL first_valid: got %b want 1", valid_o); end
        n_cmp++; if (data_o !== 24'h111111) begin n_bad++; $display("FAIL first_data: got %h want 111111", data_o); end
        pix_valid_i = 1'b0;
        tick();
        n_cmp++; if (valid_o !== 1'b0 || data_o !== 24'h111111) begin n_bad++; $display("FAIL idle_hold: got %b/%h want 0/111111", valid_o, data_o); end
    endtask

    task automatic test_commit();
        csr_write(3'd0, 32'h0000_1921);
        sof_pulse();
        n_cmp++; if (src_sel_o !== 4'd0 || update_pending_o !== 1'b0) begin n_bad++; $display("FAIL nocommit: got src %0d pend %b want 0/0", src_sel_o, update_pending_o); end
        csr_write(3'd0, 32'h0000_1929);
        n_cmp++; if (update_pending_o !== 1'b1 || src_sel_o !== 4'd0) begin n_bad++; $display("FAIL commit_pending: got pend %b src %0d want 1/0", update_pending_o, src_sel_o); end
        sof_pulse();
        n_cmp++; if (src_sel_o !== 4'd2 || update_pending_o !== 1'b0) begin n_bad++; $display("FAIL commit_apply: got src %0d pend %b want 2/0", src_sel_o, update_pending_o); end
        pix_valid_i = 1'b1;
        tick();
        pix_valid_i = 1'b0;
        n_cmp++; if (data_o !== 24'h333333 || valid_o !== 1'b1) begin n_bad++; $display("FAIL src2_data: got %h/%b want 333333/1", data_o, valid_o); end
    endtask

    task automatic test_commit_on_sof();
        avs_address_i = 3'd0; avs_writedata_i = 32'h0000_1939; avs_write_i = 1'b1; sof_i = 1'b1;
        tick();
        avs_write_i = 1'b0; sof_i = 1'b0;
        n_cmp++; if (update_pending_o !== 1'b1 || src_sel_o !== 4'd2) begin n_bad++; $display("FAIL sof_commit_defer: got pend %b src %0d want 1/2", update_pending_o, src_sel_o); end
        sof_pulse();
        n_cmp++; if (update_pending_o !== 1'b0 || src_sel_o !== 4'd3) begin n_bad++; $display("FAIL sof_commit_next: got pend %b src %0d want 0/3", update_pending_o, src_sel_o); end
    endtask

    task automatic test_auto_cycle();
        csr_write(3'd0, 32'h0002_193D);
        sof_pulse();
        n_cmp++; if (src_sel_o !== 4'd3) begin n_bad++; $display("FAIL auto_start: got %0d want 3", src_sel_o); end
        sof_pulse();
        csr_read(3'd4);
        n_cmp++; if (avs_readdata_o !== 32'h0001_0030 || avs_readdatavalid_o !== 1'b1) begin n_bad++; $display("FAIL auto_status: got %h want 00010030", avs_readdata_o); end
        sof_pulse();
        n_cmp++; if (src_sel_o !== 4'd4) begin n_bad++; $display("FAIL auto_2: got %0d want 4", src_sel_o); end
        repeat (2) sof_pulse();
        n_cmp++; if (src_sel_o !== 4'd0) begin n_bad++; $display("FAIL auto_4: got %0d want 0", src_sel_o); end
        repeat (2) sof_pulse();
        n_cmp++; if (src_sel_o !== 4'd1) begin n_bad++; $display("FAIL auto_6: got %0d want 1", src_sel_o); end
        csr_write(3'd0, 32'h0000_1929);
        sof_pulse();
        repeat (3) sof_pulse();
        n_cmp++; if (src_sel_o !== 4'd2) begin n_bad++; $display("FAIL auto_off: got %0d want 2", src_sel_o); end
    endtask

    task automatic test_src_clamp_enable();
        csr_write(3'd0, 32'h0000_1999);
        sof_pulse();
        n_cmp++; if (src_sel_o !== 4'd9) begin n_bad++; $display("FAIL clamp_sel: got %0d want 9", src_sel_o); end
        pix_valid_i = 1'b1;
        tick();
        n_cmp++; if (data_o !== 24'h555555) begin n_bad++; $display("FAIL clamp_data: got %h want 555555", data_o); end
        pix_valid_i = 1'b0;
        csr_write(3'd0, 32'h0000_1998);
        sof_pulse();
        src_data_i[4*24 +: 24] = 24'hABCDEF;
        src_data_i[0 +: 24]    = 24'hFEDCBA;
        pix_valid_i = 1'b1;
        tick();
        n_cmp++; if (enable_o !== 1'b0 || valid_o !== 1'b0) begin n_bad++; $display("FAIL disable_valid: got en %b valid %b want 0/0", enable_o, valid_o); end
        n_cmp++; if (data_o !== 24'h555555) begin n_bad++; $display("FAIL disable_hold: got %h want 555555", data_o); end
        pix_valid_i = 1'b0;
        load_sources();
    endtask

    task automatic test_read();
        csr_write(3'd1, 32'd1024);
        csr_read(3'd1);
        n_cmp++; if (avs_readdatavalid_o !== 1'b1 || avs_readdata_o !== 32'd1024) begin n_bad++; $display("FAIL rd_width: got %b/%0d want 1/1024", avs_readdatavalid_o, avs_readdata_o); end
        tick();
        n_cmp++; if (avs_readdatavalid_o !== 1'b0 || avs_readdata_o !== 32'd1024) begin n_bad++; $display("FAIL rd_hold: got %b/%0d want 0/1024", avs_readdatavalid_o, avs_readdata_o); end
        n_cmp++; if (width_o !== 32'd800) begin n_bad++; $display("FAIL width_shadow: got %0d want 800", width_o); end
        csr_read(3'd6);
        n_cmp++; if (avs_readdata_o !== 32'h0) begin n_bad++; $display("FAIL rd_unmapped: got %h want 0", avs_readdata_o); end
        avs_address_i = 3'd2; avs_writedata_i = 32'd777; avs_write_i = 1'b1; avs_read_i = 1'b1;
        tick();
        avs_write_i = 1'b0; avs_read_i = 1'b0;
        n_cmp++; if (avs_readdata_o !== 32'd600) begin n_bad++; $display("FAIL rd_wr_same: got %0d want 600", avs_readdata_o); end
        csr_read(3'd2);
        n_cmp++; if (avs_readdata_o !== 32'd777) begin n_bad++; $display("FAIL rd_after_wr: got %0d want 777", avs_readdata_o); end
        csr_write(3'd0, 32'h0000_19A9);
        csr_read(3'd0);
        n_cmp++; if (avs_readdata_o !== 32'h0000_19A1) begin n_bad++; $display("FAIL rd_ctrl: got %h want 000019a1", avs_readdata_o); end
        csr_read(3'd4);
        n_cmp++; if (avs_readdata_o !== 32'h0000_0091) begin n_bad++; $display("FAIL rd_status: got %h want 00000091", avs_readdata_o); end
    endtask

    task automatic test_reset_mid();
        #3;
        rst_i = 1'b0;
        #1;
        n_cmp++; if (update_pending_o !== 1'b0) begin n_bad++; $display("FAIL midrst_pending: got %b want 0", update_pending_o); end
        n_cmp++; if (src_sel_o !== 4'd0 || enable_o !== 1'b1) begin n_bad++; $display("FAIL midrst_ctrl: got src %0d en %b want 0/1", src_sel_o, enable_o); end
        n_cmp++; if (width_o !== 32'd800 || height_o !== 32'd600 || color_onecolor_o !== 24'h0000FF) begin n_bad++; $display("FAIL midrst_geom: got %0d/%0d/%h want 800/600/0000ff", width_o, height_o, color_onecolor_o); end
        n_cmp++; if (data_o !== 24'h0 || valid_o !== 1'b0 || avs_readdata_o !== 32'h0) begin n_bad++; $display("FAIL midrst_regs: got %h/%b/%h want 0/0/0", data_o, valid_o, avs_readdata_o); end
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        sof_pulse();
        n_cmp++; if (src_sel_o !== 4'd0 || update_pending_o !== 1'b0 || width_o !== 32'd800) begin n_bad++; $display("FAIL midrst_dropped: got src %0d pend %b w %0d want 0/0/800", src_sel_o, update_pending_o, width_o); end
    endtask

    initial begin
        rst_i = 1'b0; avs_address_i = '0; avs_write_i = 1'b0; avs_writedata_i = '0;
        avs_read_i = 1'b0; sof_i = 1'b0; pix_valid_i = 1'b0; src_data_i = '0;
        load_sources();
        test_reset();
        test_commit();
        test_commit_on_sof();
        test_auto_cycle();
        test_src_clamp_enable();
        test_read();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
